// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory read port plus the decode-side valid/stall handshake.
// master = fetch unit, slave = memory/decode environment.
interface instr_fetch_unit_if;
  logic [31:0] instr_addr_o;
  logic [31:0] instr_data_i;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        fault_o;

  modport master (
    output instr_addr_o,
    input  instr_data_i,
    input  stall_i,
    input  redirect_valid_i,
    input  redirect_pc_i,
    output instr_valid_o,
    output instr_o,
    output pc_o,
    output pc_plus4_o,
    output fault_o
  );

  modport slave (
    input  instr_addr_o,
    output instr_data_i,
    output stall_i,
    output redirect_valid_i,
    output redirect_pc_i,
    input  instr_valid_o,
    input  instr_o,
    input  pc_o,
    input  pc_plus4_o,
    input  fault_o
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches from a single-cycle ROM, registers instructions for decode.
// Optional FETCH_PERF_CNT_EN adds fetch/stall performance counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC             = 32'h0000_0000,
  parameter logic [31:0] INSTR_MEM_SIZE_BYTES = 32'd128
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  instr_fetch_unit_if.master        bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]               fetch_cnt_o,
  output logic [31:0]               stall_cnt_o
`endif
);

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_out_q;
  logic        valid_q;
  logic        bad;
  logic        in_fetch;
  logic        do_redirect;
  logic        do_stall;
  logic        do_fault;
  logic        do_take;

  // Redirect beats stall, stall beats the address fault, so a stalled bad PC waits.
  always_comb begin
    bad         = (pc_q[1:0] != 2'b00) || (pc_q >= INSTR_MEM_SIZE_BYTES);
    in_fetch    = (state_q == FETCH);
    do_redirect = in_fetch && bus.redirect_valid_i;
    do_stall    = in_fetch && !bus.redirect_valid_i && bus.stall_i;
    do_fault    = in_fetch && !bus.redirect_valid_i && !bus.stall_i && bad;
    do_take     = in_fetch && !bus.redirect_valid_i && !bus.stall_i && !bad;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (do_fault) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    bus.instr_addr_o  = pc_q;
    bus.instr_valid_o = valid_q;
    bus.instr_o       = instr_q;
    bus.pc_o          = pc_out_q;
    bus.pc_plus4_o    = pc_out_q + 32'd4;
    bus.fault_o       = (state_q == HALT);
  end

  // Datapath; in HALT nothing is enabled, which freezes pc_q and keeps valid low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q     <= RESET_PC;
      instr_q  <= NOP;
      pc_out_q <= 32'h0000_0000;
      valid_q  <= 1'b0;
    end else if (do_redirect) begin
      pc_q    <= bus.redirect_pc_i;
      valid_q <= 1'b0;
    end else if (do_fault) begin
      valid_q <= 1'b0;
    end else if (do_take) begin
      instr_q  <= bus.instr_data_i;
      pc_out_q <= pc_q;
      valid_q  <= 1'b1;
      pc_q     <= pc_q + 32'd4;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_cnt_o <= 32'd0;
      stall_cnt_o <= 32'd0;
    end else begin
      if (do_take)  fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (do_stall) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios push expected deliveries,
// a negedge monitor pops one entry per cycle with instr_valid_o high.
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t sb_q[$];
  exp_t mon_e;

  instr_fetch_unit_if bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  instr_fetch_unit #(
    .RESET_PC             (32'h0000_0000),
    .INSTR_MEM_SIZE_BYTES (32'd128)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.master)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o (fetch_cnt),
    .stall_cnt_o (stall_cnt)
`endif
  );

  // ROM contents: word k holds 32'h1000_0000 + k.
  assign bus.instr_data_i = 32'h1000_0000 + {2'b00, bus.instr_addr_o[31:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && bus.instr_valid_o) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_valid: got pc=%h instr=%h, required no live instruction",
                 bus.pc_o, bus.instr_o);
      end else begin
        mon_e = sb_q.pop_front();
        if (bus.instr_o !== mon_e.instr || bus.pc_o !== mon_e.pc ||
            bus.pc_plus4_o !== mon_e.pc + 32'd4) begin
          bad++;
          $display("[TB] FAIL delivery: got pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                   bus.pc_o, bus.instr_o, bus.pc_plus4_o, mon_e.pc, mon_e.instr, mon_e.pc + 32'd4);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic stall, input logic redir, input logic [31:0] rpc);
    bus.stall_i          = stall;
    bus.redirect_valid_i = redir;
    bus.redirect_pc_i    = rpc;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    sb_q.push_back(e);
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    apply_stimulus(1'b0, 1'b0, 32'h0);
    step();
    step();
    check_output("rst_fault", 32'(bus.fault_o), 32'h0);
    check_output("rst_valid", 32'(bus.instr_valid_o), 32'h0);
    check_output("rst_instr", bus.instr_o, 32'h0000_0013);
    check_output("rst_pc", bus.pc_o, 32'h0);
    check_output("rst_addr", bus.instr_addr_o, 32'h0);
    rst_n = 1'b1;

    // Sequential fetch from reset.
    step(); push_exp(32'h0, 32'h1000_0000);
    check_output("seq_addr0", bus.instr_addr_o, 32'h4);
    step(); push_exp(32'h4, 32'h1000_0001);
    step(); push_exp(32'h8, 32'h1000_0002);

    // Three stalled edges hold pc_o=8.
    apply_stimulus(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(); push_exp(32'h8, 32'h1000_0002);
    end
    check_output("stall_addr", bus.instr_addr_o, 32'hC);
    apply_stimulus(1'b0, 1'b0, 32'h0);
    step(); push_exp(32'hC, 32'h1000_0003);

    // Redirect together with stall.
    apply_stimulus(1'b1, 1'b1, 32'h40);
    step();
    check_output("redir_valid", 32'(bus.instr_valid_o), 32'h0);
    check_output("redir_addr", bus.instr_addr_o, 32'h40);
    apply_stimulus(1'b0, 1'b0, 32'h0);
    step(); push_exp(32'h40, 32'h1000_0010);

    // Run off the end of memory, with a stall parked on the bad address first.
    apply_stimulus(1'b0, 1'b1, 32'h78);
    step();
    check_output("eom_addr", bus.instr_addr_o, 32'h78);
    apply_stimulus(1'b0, 1'b0, 32'h0);
    step(); push_exp(32'h78, 32'h1000_001E);
    step(); push_exp(32'h7C, 32'h1000_001F);
    apply_stimulus(1'b1, 1'b0, 32'h0);
    step(); push_exp(32'h7C, 32'h1000_001F);
    check_output("eom_stall_fault", 32'(bus.fault_o), 32'h0);
    apply_stimulus(1'b0, 1'b0, 32'h0);
    step();
    check_output("eom_fault", 32'(bus.fault_o), 32'h1);
    check_output("eom_valid", 32'(bus.instr_valid_o), 32'h0);
    check_output("eom_addr_frozen", bus.instr_addr_o, 32'h80);
`ifdef FETCH_PERF_CNT_EN
    check_output("cnt_fetch", fetch_cnt, 32'd7);
    check_output("cnt_stall", stall_cnt, 32'd4);
`endif

    // Asynchronous reset while halted.
    rst_n = 1'b0;
    #1;
    check_output("arst_fault", 32'(bus.fault_o), 32'h0);
    check_output("arst_valid", 32'(bus.instr_valid_o), 32'h0);
    check_output("arst_addr", bus.instr_addr_o, 32'h0);
    check_output("arst_instr", bus.instr_o, 32'h0000_0013);
`ifdef FETCH_PERF_CNT_EN
    check_output("arst_cnt_fetch", fetch_cnt, 32'd0);
    check_output("arst_cnt_stall", stall_cnt, 32'd0);
`endif
    rst_n = 1'b1;

    // Misaligned redirect, then HALT ignores redirect and stall.
    step(); push_exp(32'h0, 32'h1000_0000);
    apply_stimulus(1'b0, 1'b1, 32'h22);
    step();
    check_output("mis_addr", bus.instr_addr_o, 32'h22);
    check_output("mis_fault_early", 32'(bus.fault_o), 32'h0);
    apply_stimulus(1'b0, 1'b0, 32'h0);
    step();
    check_output("mis_fault", 32'(bus.fault_o), 32'h1);
    check_output("mis_valid", 32'(bus.instr_valid_o), 32'h0);
    apply_stimulus(1'b1, 1'b1, 32'h10);
    step();
    step();
    check_output("halt_addr", bus.instr_addr_o, 32'h22);
    check_output("halt_fault", 32'(bus.fault_o), 32'h1);
    rst_n = 1'b0;
    #1;
    check_output("halt_rst_fault", 32'(bus.fault_o), 32'h0);
    apply_stimulus(1'b0, 1'b0, 32'h0);
    step();

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL sb_drain: got %0d pending deliveries, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
